// File: rtl/disparity_encoder_pkg.sv
// Shared constants and the level-to-code helper for the disparity encoder.
// Rounding mode is selected by DISPARITY_ENCODER_ROUND_EN in the top level.
package disparity_encoder_pkg;

    localparam int LEVEL_STEP  = 17;
    localparam int RECIP_MUL   = 241;
    localparam int RECIP_SHIFT = 12;
    localparam int MAX_LEVEL   = 15;
    localparam int CODE_W      = 6;
    localparam int PIX_W       = 8;
    localparam int PROD_W      = 17;

    // prod >> RECIP_SHIFT equals floor(x/17) for every x up to 263
    function automatic logic [CODE_W-1:0] level_to_code(input logic [PROD_W-1:0] prod);
        logic [4:0] level;
        level = prod[RECIP_SHIFT +: 5];
        if (level > 5'(MAX_LEVEL))
            level = 5'(MAX_LEVEL);
        return {level[3:0], 2'b00};
    endfunction

endpackage

// File: rtl/disparity_encoder_frame_position_counter.sv
// Column/row tracker for a pixel stream: eol/eof tags, sof resync and a sticky
// sync error that becomes visible together with the offending pixel's output.
module disparity_encoder_frame_position_counter #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int COL_W      = 9,
    parameter int ROW_W      = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic advance,
    input  logic accept,
    input  logic sof,
    output logic eol,
    output logic eof,
    output logic sync_err
);

    logic [COL_W-1:0] col;
    logic [COL_W-1:0] eff_col;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] eff_row;
    logic             resync;
    logic             err_pend;

    // A mid-frame sof snaps the current pixel to the frame origin
    always_comb begin
        resync  = sof && ((col != '0) || (row != '0));
        eff_col = resync ? '0 : col;
        eff_row = resync ? '0 : row;
        eol     = (eff_col == COL_W'(IMG_WIDTH - 1));
        eof     = eol && (eff_row == ROW_W'(IMG_HEIGHT - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col      <= '0;
            row      <= '0;
            err_pend <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (accept) begin
                if (eol) begin
                    col <= '0;
                    row <= eof ? '0 : eff_row + 1'b1;
                end else begin
                    col <= eff_col + 1'b1;
                    row <= eff_row;
                end
            end
            // err_pend rides alongside stage 1 so the flag lands with the output
            if (advance) begin
                err_pend <= accept && resync;
                sync_err <= sync_err || err_pend;
            end
        end
    end

endmodule

// File: rtl/disparity_encoder.sv
// Re-encodes 8-bit depth pixels into 6-bit disparity codes (level*4) over a
// two-stage stall-able pipeline. DISPARITY_ENCODER_ROUND_EN selects round-to-nearest.
module disparity_encoder
    import disparity_encoder_pkg::*;
#(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int COL_W      = 9,
    parameter int ROW_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              sof_in,
    input  logic [PIX_W-1:0]  data_in,
    output logic              ready_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CODE_W-1:0] data_out,
    output logic              eol_out,
    output logic              eof_out,
    output logic              sync_err
);

`ifdef DISPARITY_ENCODER_ROUND_EN
    localparam bit ROUNDING = 1'b1;
`else
    localparam bit ROUNDING = 1'b0;
`endif
    localparam logic [PIX_W:0] BIAS = ROUNDING ? (PIX_W+1)'(LEVEL_STEP / 2) : '0;

    logic              advance;
    logic              accept;
    logic [PIX_W:0]    x;
    logic              tag_eol;
    logic              tag_eof;
    logic              s1_valid;
    logic              s1_eol;
    logic              s1_eof;
    logic [PROD_W-1:0] s1_prod;

    assign advance   = !valid_out || ready_in;
    assign ready_out = advance;
    assign accept    = valid_in && advance;
    assign x         = {1'b0, data_in} + BIAS;

    disparity_encoder_frame_position_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .COL_W      (COL_W),
        .ROW_W      (ROW_W)
    ) u_position (
        .clock    (clock),
        .reset    (reset),
        .advance  (advance),
        .accept   (accept),
        .sof      (sof_in),
        .eol      (tag_eol),
        .eof      (tag_eof),
        .sync_err (sync_err)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_eol    <= 1'b0;
            s1_eof    <= 1'b0;
            s1_prod   <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            eol_out   <= 1'b0;
            eof_out   <= 1'b0;
        end else if (advance) begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_prod <= PROD_W'(x) * PROD_W'(RECIP_MUL);
                s1_eol  <= tag_eol;
                s1_eof  <= tag_eof;
            end
            valid_out <= s1_valid;
            data_out  <= level_to_code(s1_prod);
            eol_out   <= s1_eol;
            eof_out   <= s1_eof;
        end
    end

endmodule
